// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e : fetch controller state encoding
//   RESET_VECTOR  : first PC after reset, shared with the PC stage
//   NOP_INST      : instruction word handed to decode in place of a fetch
// ---------------------------------------------------------------------------
package if_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
// Consumer end of the PC interface. Takes one fetch address at a time, runs
// a single transaction on an SRAM-like request/addr_ok/data_ok instruction
// bus, buffers the returned word and presents instruction + PC to decode
// with a valid/accept handshake. A redirect (Flush) kills the current fetch
// and the buffered instruction, including a response already in flight.
// At most one bus transaction is outstanding.
//
// Ports
//   Clk, Rst            clock (rising edge), async active-low reset
//   PCIn/PCValid/PCReady fetch address from the PC stage
//   Flush               redirect, highest priority event in every state
//   InstReq/InstAddr    bus request and address
//   InstAddrOk          bus accepted the address this cycle
//   InstDataOk/InstRData bus read data
//   InstOut/InstPC/InstValid/InstAccept  decode handshake
//   ExcAdEL             fetch address error, qualified by InstValid
//
// Build option
//   FETCH_ALIGN_CHECK_EN : a PC with PCIn[1:0]!=0 skips the bus and is
//                          handed to decode as a nop with ExcAdEL=1.
//                          When undefined ExcAdEL stays 0 and the low two
//                          address bits are forced to 0 on the bus.
// ---------------------------------------------------------------------------
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PCIn,
  input  logic              PCValid,
  output logic              PCReady,
  input  logic              Flush,
  output logic              InstReq,
  output logic [ADDR_W-1:0] InstAddr,
  input  logic              InstAddrOk,
  input  logic              InstDataOk,
  input  logic [INST_W-1:0] InstRData,
  output logic [INST_W-1:0] InstOut,
  output logic [ADDR_W-1:0] InstPC,
  output logic              InstValid,
  input  logic              InstAccept,
  output logic              ExcAdEL
);

  fetch_state_e      r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;
  logic              r_exc;

  logic              w_pc_take;
  logic              w_misalign;

  // PCReady must react to Flush/InstAccept in the same cycle, so it is the
  // only combinational output.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the
    // output; a missing branch would otherwise infer a latch.
    PCReady = 1'b0;
    case (r_state)
      IDLE:    PCReady = ~Flush;
      HOLD:    PCReady = InstAccept & ~Flush;
      default: PCReady = 1'b0;
    endcase
  end

  assign w_pc_take = PCValid & PCReady;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign = |PCIn[1:0];
  assign InstAddr   = r_pc;
`else
  assign w_misalign = 1'b0;
  assign InstAddr   = {r_pc[ADDR_W-1:2], 2'b00};
`endif

  assign InstReq   = r_req;
  assign InstPC    = r_pc;
  assign InstOut   = r_inst;
  assign InstValid = r_valid;
  assign ExcAdEL   = r_exc;

  // NOTE: all state and output registers use non-blocking assignments so
  // every branch sees the pre-edge values and later assignments in the
  // block cleanly override earlier ones.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_pc    <= '0;
      r_inst  <= INST_W'(NOP_INST);
      r_valid <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: ;  // a new PC is handled by the common take logic below

        REQ: begin
          if (Flush) begin
            // Withdrawing an unaccepted request is legal; an accepted one
            // still owes us a data beat that must be swallowed.
            r_req   <= 1'b0;
            r_state <= InstAddrOk ? DROP : IDLE;
          end else if (InstAddrOk) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (Flush) begin
            r_state <= InstDataOk ? IDLE : DROP;
          end else if (InstDataOk) begin
            r_inst  <= InstRData;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end

        DROP: begin
          if (InstDataOk) r_state <= IDLE;
        end

        HOLD: begin
          if (Flush || InstAccept) begin
            r_valid <= 1'b0;
            r_exc   <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase

      // PCReady is only ever high in IDLE or HOLD-with-accept, so taking a
      // PC overrides whatever the state branch chose above. This gives the
      // back-to-back HOLD -> REQ path without duplicating the latch logic.
      if (w_pc_take) begin
        r_pc <= PCIn;
        if (w_misalign) begin
          r_inst  <= INST_W'(NOP_INST);
          r_valid <= 1'b1;
          r_exc   <= 1'b1;
          r_state <= HOLD;
        end else begin
          r_req   <= 1'b1;
          r_state <= REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Directed bench for if_fetch_ctrl. Stimulus pushes the expected
// instruction/PC/exception into a queue when the bus returns data; a
// monitor pops and compares on every decode transfer (InstValid &
// InstAccept). Cycle-level protocol checks are made inline.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;
  import if_pkg::*;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic [ADDR_W-1:0] PCIn = '0;
  logic              PCValid = 1'b0;
  logic              PCReady;
  logic              Flush = 1'b0;
  logic              InstReq;
  logic [ADDR_W-1:0] InstAddr;
  logic              InstAddrOk = 1'b0;
  logic              InstDataOk = 1'b0;
  logic [INST_W-1:0] InstRData = '0;
  logic [INST_W-1:0] InstOut;
  logic [ADDR_W-1:0] InstPC;
  logic              InstValid;
  logic              InstAccept = 1'b0;
  logic              ExcAdEL;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] b2b_pc   [3] = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
  logic [31:0] b2b_data [3] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003};

  if_fetch_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .PCIn       (PCIn),
    .PCValid    (PCValid),
    .PCReady    (PCReady),
    .Flush      (Flush),
    .InstReq    (InstReq),
    .InstAddr   (InstAddr),
    .InstAddrOk (InstAddrOk),
    .InstDataOk (InstDataOk),
    .InstRData  (InstRData),
    .InstOut    (InstOut),
    .InstPC     (InstPC),
    .InstValid  (InstValid),
    .InstAccept (InstAccept),
    .ExcAdEL    (ExcAdEL)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc, input logic exc);
    exp_t t;
    t.inst = inst;
    t.pc   = pc;
    t.exc  = exc;
    exp_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Zero-wait fetch with decode accepting immediately; leaves the DUT in IDLE.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
    InstAccept = 1'b1;
    PCIn = pc; PCValid = 1'b1; #1;
    check("fetch_pcready", PCReady, 1);
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1; #1;
    check("fetch_req", InstReq, 1);
    check("fetch_addr", InstAddr, {pc[31:2], 2'b00});
    tick(); InstAddrOk = 1'b0; InstDataOk = 1'b1; InstRData = data;
    expect_inst(data, pc, 1'b0);
    tick(); InstDataOk = 1'b0; #1;
    check("fetch_valid", InstValid, 1);
    tick(); #1;
    check("fetch_done", InstValid, 0);
  endtask

  // Scoreboard monitor: every decode transfer must match the queue head.
  always @(negedge Clk) begin
    if (Rst && InstValid && InstAccept) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %0h inst %0h expected none", InstPC, InstOut);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_inst", InstOut, mon_e.inst);
        check("mon_pc", InstPC, mon_e.pc);
        check("mon_exc", ExcAdEL, mon_e.exc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    #1;
    check("rst_req", InstReq, 0);
    check("rst_addr", InstAddr, 0);
    check("rst_valid", InstValid, 0);
    check("rst_out", InstOut, 0);
    check("rst_pc", InstPC, 0);
    check("rst_exc", ExcAdEL, 0);
    tick(); tick();
    Rst = 1'b1;
    tick();

    // ---- single fetch with a 5-cycle decode stall
    InstAccept = 1'b0;
    PCIn = RESET_VECTOR; PCValid = 1'b1; #1;
    check("single_pcready", PCReady, 1);
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1; #1;
    check("single_req", InstReq, 1);
    check("single_addr", InstAddr, 32'hBFC0_0000);
    check("single_pcready_req", PCReady, 0);
    tick(); InstAddrOk = 1'b0; InstDataOk = 1'b1; InstRData = 32'h2408_0001; #1;
    check("single_req_wait", InstReq, 0);
    expect_inst(32'h2408_0001, 32'hBFC0_0000, 1'b0);
    tick(); InstDataOk = 1'b0; #1;
    check("single_valid_c3", InstValid, 1);
    check("single_out", InstOut, 32'h2408_0001);
    check("single_pc", InstPC, 32'hBFC0_0000);
    PCIn = 32'hBFC0_0004; PCValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("stall_valid", InstValid, 1);
      check("stall_out", InstOut, 32'h2408_0001);
      check("stall_pc", InstPC, 32'hBFC0_0000);
      check("stall_pcready", PCReady, 0);
      check("stall_req", InstReq, 0);
    end
    PCValid = 1'b0; InstAccept = 1'b1;
    tick(); #1;
    check("single_released", InstValid, 0);

    // ---- back-to-back, zero-wait bus, decode always accepting
    InstAccept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCIn = b2b_pc[i]; PCValid = 1'b1; #1;
      check("b2b_pcready", PCReady, 1);
      if (i > 0) check("b2b_valid_period", InstValid, 1);
      tick(); PCValid = 1'b0; InstAddrOk = 1'b1; #1;
      check("b2b_req", InstReq, 1);
      check("b2b_addr", InstAddr, b2b_pc[i]);
      tick(); InstAddrOk = 1'b0; InstDataOk = 1'b1; InstRData = b2b_data[i];
      expect_inst(b2b_data[i], b2b_pc[i], 1'b0);
      tick(); InstDataOk = 1'b0;
    end
    #1;
    check("b2b_last_valid", InstValid, 1);
    tick(); #1;
    check("b2b_idle", InstValid, 0);

    // ---- flush in WAIT, data arrives the next cycle and is dropped
    PCIn = 32'hBFC0_0010; PCValid = 1'b1;
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1;
    tick(); InstAddrOk = 1'b0; Flush = 1'b1; #1;
    check("fwait_pcready_flush", PCReady, 0);
    tick(); Flush = 1'b0; PCIn = 32'hBFC0_0100; PCValid = 1'b1;
    InstDataOk = 1'b1; InstRData = 32'h1111_1111; #1;
    check("fwait_pcready_drop", PCReady, 0);
    tick(); InstDataOk = 1'b0; #1;
    check("fwait_no_valid", InstValid, 0);
    check("fwait_pcready_idle", PCReady, 1);
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1; #1;
    check("fwait_next_req", InstReq, 1);
    check("fwait_next_addr", InstAddr, 32'hBFC0_0100);
    tick(); InstAddrOk = 1'b0; InstDataOk = 1'b1; InstRData = 32'h2222_2222;
    expect_inst(32'h2222_2222, 32'hBFC0_0100, 1'b0);
    tick(); InstDataOk = 1'b0; #1;
    check("fwait_next_valid", InstValid, 1);
    tick();

    // ---- flush in REQ before address accept, and flush in IDLE
    Flush = 1'b1; PCIn = 32'hBFC0_0200; PCValid = 1'b1; #1;
    check("fidle_pcready", PCReady, 0);
    Flush = 1'b0; #1;
    check("idle_pcready", PCReady, 1);
    tick(); PCValid = 1'b0; Flush = 1'b1; #1;
    check("freq_req_before", InstReq, 1);
    tick(); Flush = 1'b0; #1;
    check("freq_req_dropped", InstReq, 0);
    check("freq_idle_ready", PCReady, 1);
    fetch(32'hBFC0_0204, 32'h3333_3333);

    // ---- flush together with address accept: DROP swallows the data
    PCIn = 32'hBFC0_0300; PCValid = 1'b1;
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1; Flush = 1'b1;
    tick(); InstAddrOk = 1'b0; Flush = 1'b0; PCIn = 32'hBFC0_0304; PCValid = 1'b1; #1;
    check("fboth_pcready", PCReady, 0);
    check("fboth_req", InstReq, 0);
    tick(); Flush = 1'b1; InstDataOk = 1'b1; InstRData = 32'h4444_4444; #1;
    check("fboth_pcready_data", PCReady, 0);
    tick(); Flush = 1'b0; InstDataOk = 1'b0; PCValid = 1'b0; #1;
    check("fboth_no_valid", InstValid, 0);
    fetch(32'hBFC0_0304, 32'h5555_5555);

    // ---- flush during a decode stall
    InstAccept = 1'b0;
    PCIn = 32'hBFC0_0020; PCValid = 1'b1;
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1;
    tick(); InstAddrOk = 1'b0; InstDataOk = 1'b1; InstRData = 32'h6666_6666;
    tick(); InstDataOk = 1'b0;
    tick(); tick(); Flush = 1'b1; #1;
    check("fhold_valid_before", InstValid, 1);
    check("fhold_out", InstOut, 32'h6666_6666);
    tick(); Flush = 1'b0; #1;
    check("fhold_valid_after", InstValid, 0);

    // ---- async reset in WAIT, stray data afterwards
    InstAccept = 1'b1;
    PCIn = 32'hBFC0_0400; PCValid = 1'b1;
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1; #1;
    check("arst_req_before", InstReq, 1);
    tick(); InstAddrOk = 1'b0;
    #2 Rst = 1'b0;
    #1;
    check("arst_req", InstReq, 0);
    check("arst_addr", InstAddr, 0);
    check("arst_out", InstOut, 0);
    check("arst_pc", InstPC, 0);
    check("arst_valid", InstValid, 0);
    check("arst_exc", ExcAdEL, 0);
    #2 Rst = 1'b1;
    tick(); InstDataOk = 1'b1; InstRData = 32'hDEAD_BEEF;
    tick(); InstDataOk = 1'b0; #1;
    check("arst_stray_valid", InstValid, 0);
    check("arst_stray_req", InstReq, 0);
    tick(); #1;
    check("arst_stray_valid2", InstValid, 0);

    // ---- misaligned PC
`ifdef FETCH_ALIGN_CHECK_EN
    InstAccept = 1'b0;
    PCIn = 32'hBFC0_0002; PCValid = 1'b1; #1;
    check("align_pcready", PCReady, 1);
    tick(); PCValid = 1'b0; #1;
    check("align_no_req", InstReq, 0);
    check("align_valid", InstValid, 1);
    check("align_exc", ExcAdEL, 1);
    check("align_out", InstOut, 0);
    check("align_pc", InstPC, 32'hBFC0_0002);
    expect_inst(32'h0, 32'hBFC0_0002, 1'b1);
    InstAccept = 1'b1;
    tick(); #1;
    check("align_valid_clr", InstValid, 0);
    check("align_exc_clr", ExcAdEL, 0);
`else
    InstAccept = 1'b1;
    PCIn = 32'hBFC0_0006; PCValid = 1'b1;
    tick(); PCValid = 1'b0; InstAddrOk = 1'b1; #1;
    check("noalign_req", InstReq, 1);
    check("noalign_addr", InstAddr, 32'hBFC0_0004);
    check("noalign_pc", InstPC, 32'hBFC0_0006);
    check("noalign_exc", ExcAdEL, 0);
    tick(); InstAddrOk = 1'b0; InstDataOk = 1'b1; InstRData = 32'h7777_7777;
    expect_inst(32'h7777_7777, 32'hBFC0_0006, 1'b0);
    tick(); InstDataOk = 1'b0;
    tick();
`endif

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
